// File: rtl/regfile_alu_seq_if.sv
// Command/status bus between the switch/tick front end, the sequencer and the display read port.
interface regfile_alu_seq_if #(
  parameter int WIDTH = 4,
  parameter int SELW  = 4
);
  logic             tick;
  logic             cmd_req;
  logic [2:0]       cmd_op;
  logic [SELW-1:0]  src_a;
  logic [SELW-1:0]  src_b;
  logic [SELW-1:0]  dst;
  logic [SELW-1:0]  rd_sel;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             done;
  logic             err;
  logic             carry;
  logic             zero;

  modport master (output tick, cmd_req, cmd_op, src_a, src_b, dst, rd_sel,
                  input  rd_data, busy, done, err, carry, zero);
  modport slave  (input  tick, cmd_req, cmd_op, src_a, src_b, dst, rd_sel,
                  output rd_data, busy, done, err, carry, zero);
endinterface

// File: rtl/regfile_alu_seq.sv
// NREG x WIDTH register file with one shared ALU, driven by a debounced switch command
// through a fixed IDLE/FETCH/EXEC/WB sequence.
module regfile_alu_seq #(
  parameter int WIDTH = 4,
  parameter int NREG  = 4
) (
  input logic              clk,
  input logic              rst,
  regfile_alu_seq_if.slave bus
);
  localparam int SELW = 4;
  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;
  typedef enum logic [2:0] {OP_INC, OP_DEC, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MOV, OP_CLR} op_t;
  typedef struct packed {
    logic [2:0]      op;
    logic [SELW-1:0] a;
    logic [SELW-1:0] b;
    logic [SELW-1:0] d;
  } cmd_t;

  state_t                     state, state_n;
  cmd_t                       cmd;
  logic [NREG-1:0][WIDTH-1:0] regs;
  logic [WIDTH-1:0]           op_a, op_b, res_q;
  logic                       carry_h, carry_r, zero_r;
  logic                       s0, armed, go, dst_ok;
  logic [WIDTH:0]             alu_w;
  logic                       alu_c;

  function automatic logic [WIDTH-1:0] rd_reg(input logic [NREG-1:0][WIDTH-1:0] r,
                                              input logic [SELW-1:0] sel);
    rd_reg = '0;
    for (int i = 0; i < NREG; i++)
      if (sel == SELW'(i)) rd_reg = r[i];
  endfunction

  // After the shift the newest sample is cmd_req and the older one is today's s0,
  // so the second-high tick fires without waiting for another tick.
  assign go     = bus.tick & bus.cmd_req & s0 & armed;
  assign dst_ok = {1'b0, cmd.d} < (SELW+1)'(NREG);

  always_ff @(posedge clk) begin
    if (!rst) begin
      s0    <= 1'b0;
      armed <= 1'b0;
    end else if (bus.tick) begin
      s0 <= bus.cmd_req;
      if (!bus.cmd_req && !s0) armed <= 1'b1;
      else if (go)             armed <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n  = state;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    bus.err  = 1'b0;
    unique case (state)
      IDLE:  if (go) state_n = FETCH;
      FETCH: begin state_n = EXEC; bus.busy = 1'b1; end
      EXEC:  begin state_n = WB;   bus.busy = 1'b1; end
      WB: begin
        state_n  = IDLE;
        bus.busy = 1'b1;
        bus.done = 1'b1;
        bus.err  = !dst_ok;
      end
    endcase
  end

  always_comb begin
    alu_w = '0;
    alu_c = carry_r;
    unique case (op_t'(cmd.op))
      OP_INC: begin alu_w = {1'b0, op_a} + ONE;         alu_c = alu_w[WIDTH]; end
      OP_DEC: begin alu_w = {1'b0, op_a} - ONE;         alu_c = alu_w[WIDTH]; end
      OP_ADD: begin alu_w = {1'b0, op_a} + {1'b0, op_b}; alu_c = alu_w[WIDTH]; end
      OP_SUB: begin alu_w = {1'b0, op_a} - {1'b0, op_b}; alu_c = alu_w[WIDTH]; end
      OP_AND: begin alu_w = {1'b0, op_a & op_b};         alu_c = 1'b0; end
      OP_OR:  begin alu_w = {1'b0, op_a | op_b};         alu_c = 1'b0; end
      OP_MOV: alu_w = {1'b0, op_a};
      OP_CLR: alu_w = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      regs    <= '0;
      cmd     <= '0;
      op_a    <= '0;
      op_b    <= '0;
      res_q   <= '0;
      carry_h <= 1'b0;
      carry_r <= 1'b0;
      zero_r  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (go) cmd <= '{op: bus.cmd_op, a: bus.src_a, b: bus.src_b, d: bus.dst};
        FETCH: begin
          op_a <= rd_reg(regs, cmd.a);
          op_b <= rd_reg(regs, cmd.b);
        end
        EXEC: begin
          res_q   <= alu_w[WIDTH-1:0];
          carry_h <= alu_c;
        end
        WB: begin
          // Flags update even when an out-of-range dst suppresses the write.
          for (int i = 0; i < NREG; i++)
            if (cmd.d == SELW'(i)) regs[i] <= res_q;
          carry_r <= carry_h;
          zero_r  <= (res_q == '0);
        end
      endcase
    end
  end

  assign bus.rd_data = rd_reg(regs, bus.rd_sel);
  assign bus.carry   = carry_r;
  assign bus.zero    = zero_r;
endmodule

// File: tb/tb_regfile_alu_seq.sv
// Randomized + directed bench for regfile_alu_seq against a command-level reference model.
module tb_regfile_alu_seq;
  localparam int WIDTH = 4, NREG = 4, M = 1 << WIDTH, TP = 10;

  logic clk = 1'b0, rst = 1'b0;
  regfile_alu_seq_if #(.WIDTH(WIDTH)) bus();
  regfile_alu_seq #(.WIDTH(WIDTH), .NREG(NREG)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int tcnt = 0;
  bit rd_auto = 1'b1;

  // reference model: architectural state plus cycles elapsed since an accepted command
  int mreg[NREG];
  int mcar = 0, mzero = 0, age = 0, mdst = 0, mres = 0, mc = 0;
  int q[$];
  bit started = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void alu(int op, int a, int b, int cin, output int r, output int c);
    case (op)
      0: begin r = (a + 1) % M;     c = (a + 1 >= M); end
      1: begin r = (a + M - 1) % M; c = (a == 0); end
      2: begin r = (a + b) % M;     c = (a + b >= M); end
      3: begin r = (a - b + M) % M; c = (a < b); end
      4: begin r = a & b;           c = 0; end
      5: begin r = a | b;           c = 0; end
      6: begin r = a;               c = cin; end
      default: begin r = 0;         c = cin; end
    endcase
  endfunction

  function automatic bit has_low_pair();
    for (int i = 0; i + 1 < q.size(); i++)
      if (q[i] == 0 && q[i+1] == 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int mread(int sel);
    return (sel < NREG) ? mreg[sel] : 0;
  endfunction

  always @(posedge clk) begin
    bit idle, fire;
    if (!rst) begin
      foreach (mreg[i]) mreg[i] = 0;
      mcar = 0; mzero = 0; age = 0;
      q = '{0};
    end else begin
      idle = (age == 0);
      if (age == 3) begin
        if (mdst < NREG) mreg[mdst] = mres;
        mcar = mc; mzero = (mres == 0); age = 0;
      end else if (age != 0) age++;
      if (bus.tick) begin
        q.push_back(int'(bus.cmd_req));
        fire = q.size() >= 2 && q[q.size()-1] == 1 && q[q.size()-2] == 1 && has_low_pair();
        if (fire) begin
          q.delete();
          if (idle) begin
            alu(int'(bus.cmd_op), mread(int'(bus.src_a)), mread(int'(bus.src_b)), mcar, mres, mc);
            mdst = int'(bus.dst);
            age  = 1;
          end
        end
      end
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("rd_data", bus.rd_data, mread(int'(bus.rd_sel)));
      chk("busy",    bus.busy,    age != 0);
      chk("done",    bus.done,    age == 3);
      chk("err",     bus.err,     age == 3 && mdst >= NREG);
      chk("carry",   bus.carry,   mcar);
      chk("zero",    bus.zero,    mzero);
    end
  end

  initial begin
    bus.tick = 1'b0;
    forever begin
      @(posedge clk); #2;
      tcnt     = (tcnt + 1) % TP;
      bus.tick = (tcnt == 0);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rd_auto) bus.rd_sel = 4'($urandom_range(0, 15));
  end

  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin @(posedge clk); n++; end while (!bus.tick && n < 4*TP);
    #2;
  endtask

  task automatic peek(string name, int sel, int exp);
    rd_auto = 1'b0;
    bus.rd_sel = 4'(sel);
    #1;
    chk(name, bus.rd_data, exp);
    rd_auto = 1'b1;
  endtask

  // low, low, high, high; go lands on the second high tick
  task automatic issue(int op, int a, int b, int d, bit rst_exec = 1'b0);
    bus.cmd_op = 3'(op); bus.src_a = 4'(a); bus.src_b = 4'(b); bus.dst = 4'(d);
    bus.cmd_req = 1'b0;
    wait_tick(); wait_tick();
    bus.cmd_req = 1'b1;
    wait_tick(); wait_tick();
    cyc(1);
    chk("busy_exec", bus.busy, 1);
    if (rst_exec) begin
      rst = 1'b0;
      cyc(1);
      rst = 1'b1;
      chk("abort_busy", bus.busy, 0);
      chk("abort_done", bus.done, 0);
      cyc(2);
    end else begin
      cyc(1);
      chk("done_at_go3", bus.done, 1);
      chk("err_at_go3",  bus.err,  d >= NREG);
      cyc(2);
    end
  endtask

  initial begin
    int nb;
    bus.cmd_req = 1'b1; bus.cmd_op = '0; bus.src_a = '0; bus.src_b = '0;
    bus.dst = '0; bus.rd_sel = '0;
    cyc(3);
    rst = 1'b1;
    repeat (5) wait_tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_carry", bus.carry, 0);
    chk("rst_zero", bus.zero, 0);
    for (int i = 0; i < NREG; i++) peek("rst_reg", i, 0);

    issue(7, 0, 0, 0);
    issue(1, 0, 0, 0);
    peek("dec_r0", 0, 15);
    chk("dec_carry", bus.carry, 1);
    issue(0, 0, 0, 0);
    peek("inc_r0", 0, 0);
    chk("inc_carry", bus.carry, 1);
    chk("inc_zero", bus.zero, 1);

    issue(7, 0, 0, 1);
    repeat (3) issue(0, 1, 0, 1);
    issue(0, 1, 0, 2);
    issue(0, 2, 0, 2);
    peek("r1_3", 1, 3);
    peek("r2_5", 2, 5);

    issue(3, 1, 2, 3);
    peek("sub_r3", 3, 14);
    chk("sub_carry", bus.carry, 1);
    chk("sub_zero", bus.zero, 0);
    issue(2, 1, 2, 3);
    peek("add_r3", 3, 8);
    chk("add_carry", bus.carry, 0);

    issue(3, 1, 2, 3);
    issue(6, 1, 0, 1);
    peek("mov_r1", 1, 3);
    chk("mov_carry", bus.carry, 1);
    issue(4, 1, 2, 0);
    peek("and_r0", 0, 1);
    chk("and_carry", bus.carry, 0);

    issue(3, 1, 1, NREG);
    chk("oob_zero", bus.zero, 1);
    peek("oob_r0", 0, 1);
    peek("oob_r1", 1, 3);
    peek("oob_r2", 2, 5);
    peek("oob_r3", 3, 14);

    bus.cmd_req = 1'b0;
    wait_tick(); wait_tick();
    bus.cmd_req = 1'b1;
    wait_tick();
    bus.cmd_req = 1'b0;
    nb = 0;
    repeat (3*TP) begin cyc(1); if (bus.busy) nb++; end
    chk("glitch_no_go", nb, 0);

    issue(2, 1, 2, 0, 1'b1);
    peek("abort_r1", 1, 0);

    repeat (25) begin
      issue($urandom_range(0, 7), $urandom_range(0, NREG), $urandom_range(0, NREG),
            $urandom_range(0, NREG));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
